// File: rtl/pwm_capture_pkg.sv
// pwm_capture_pkg: shared definitions for the PWM capture block.
//   state_t   - measurement FSM states
//   DUTY_MAX  - saturation value of the 8-bit duty_cycle output
//   cnt_max() - all-ones value of a w-bit counter (w <= 31)
package pwm_capture_pkg;

    typedef enum logic [1:0] {
        WAIT_RISE = 2'd0,
        MEAS_HIGH = 2'd1,
        MEAS_LOW  = 2'd2
    } state_t;

    localparam logic [7:0] DUTY_MAX = 8'hFF;

    function automatic logic [31:0] cnt_max(input int w);
        return 32'((64'd1 << w) - 64'd1);
    endfunction

endpackage

// File: rtl/pwm_edge_sync.sv
// pwm_edge_sync: brings the asynchronous PWM input into the clk domain.
//   clk, rst : clock and asynchronous active-high reset
//   pwm_in   : raw asynchronous PWM waveform
//   lvl      : synchronized (optionally filtered) level
//   rise     : one-cycle pulse on a 0->1 change of lvl
//   fall     : one-cycle pulse on a 1->0 change of lvl
// Build option PWM_CAPTURE_FILTER_EN inserts a glitch filter: lvl only
// follows the synchronizer after three consecutive identical samples.
// Edge latency from pwm_in is 3 cycles without the filter, 5 with it.
module pwm_edge_sync (
    input  logic clk,
    input  logic rst,
    input  logic pwm_in,
    output logic lvl,
    output logic rise,
    output logic fall
);

    logic sync1_q, sync2_q;
    logic lvl_q, lvl_d;
    logic prev_q;

`ifdef PWM_CAPTURE_FILTER_EN
    // Two older samples of the synchronizer output; together with sync2_q
    // they form the three-sample window.
    logic [1:0] hist_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hist_q <= 2'b00;
        end else begin
            hist_q <= {hist_q[0], sync2_q};
        end
    end

    always_comb begin
        lvl_d = lvl_q;
        if ((sync2_q == hist_q[0]) && (sync2_q == hist_q[1])) begin
            lvl_d = sync2_q;
        end
    end
`else
    always_comb begin
        lvl_d = sync2_q;
    end
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            lvl_q   <= 1'b0;
            prev_q  <= 1'b0;
        end else begin
            sync1_q <= pwm_in;
            sync2_q <= sync1_q;
            lvl_q   <= lvl_d;
            prev_q  <= lvl_q;
        end
    end

    assign lvl  = lvl_q;
    assign rise = lvl_q & ~prev_q;
    assign fall = ~lvl_q & prev_q;

endmodule

// File: rtl/pwm_capture.sv
// pwm_capture: measures high time and period of an asynchronous PWM input.
//   CNT_W      : width of period / high-time / timeout counters (>= 8)
//   clk, rst   : clock and asynchronous active-high reset
//   en         : measurement enable (0 parks the FSM, clears counters)
//   pwm_in     : asynchronous PWM input
//   duty_cycle : high time saturated to 8 bits
//   high_time  : last measured high phase in cycles
//   period     : last measured rising-to-rising interval in cycles
//   meas_valid : one-cycle pulse when the outputs above update
//   stuck_hi   : input high for 2^CNT_W-1 cycles without an edge
//   stuck_lo   : input low for 2^CNT_W-1 cycles without an edge
// meas_valid is a pure strobe with no back-pressure: the consumer must
// take the published values in the cycle meas_valid is high, they are
// held afterwards until the next publish.
// Build option PWM_CAPTURE_FILTER_EN enables the input glitch filter.
module pwm_capture
    import pwm_capture_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             pwm_in,
    output logic [7:0]       duty_cycle,
    output logic [CNT_W-1:0] high_time,
    output logic [CNT_W-1:0] period,
    output logic             meas_valid,
    output logic             stuck_hi,
    output logic             stuck_lo
);

    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(cnt_max(CNT_W));
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_ZERO = '0;

    logic lvl, rise, fall, edge_any, timeout;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] per_cnt_q, per_cnt_d;
    logic [CNT_W-1:0] hi_cnt_q, hi_cnt_d;
    logic [CNT_W-1:0] to_cnt_q, to_cnt_d;
    logic [CNT_W-1:0] period_q, period_d;
    logic [CNT_W-1:0] high_time_q, high_time_d;
    logic [7:0]       duty_q, duty_d;
    logic             valid_q, valid_d;
    logic             stuck_hi_q, stuck_hi_d;
    logic             stuck_lo_q, stuck_lo_d;

    pwm_edge_sync u_edge_sync (
        .clk    (clk),
        .rst    (rst),
        .pwm_in (pwm_in),
        .lvl    (lvl),
        .rise   (rise),
        .fall   (fall)
    );

    assign edge_any = rise | fall;
    // Fires only on the step into saturation, so a stuck input publishes
    // once. An edge in the same cycle clears to_cnt and wins.
    assign timeout  = en && !edge_any && (to_cnt_q == (CNT_MAX - CNT_ONE));

    always_comb begin
        state_d     = state_q;
        per_cnt_d   = per_cnt_q;
        hi_cnt_d    = hi_cnt_q;
        to_cnt_d    = to_cnt_q;
        period_d    = period_q;
        high_time_d = high_time_q;
        duty_d      = duty_q;
        valid_d     = 1'b0;
        stuck_hi_d  = stuck_hi_q;
        stuck_lo_d  = stuck_lo_q;

        if (!en) begin
            state_d   = WAIT_RISE;
            per_cnt_d = CNT_ZERO;
            hi_cnt_d  = CNT_ZERO;
            to_cnt_d  = CNT_ZERO;
        end else begin
            if (edge_any) begin
                to_cnt_d   = CNT_ZERO;
                stuck_hi_d = 1'b0;
                stuck_lo_d = 1'b0;
            end else if (to_cnt_q != CNT_MAX) begin
                to_cnt_d = to_cnt_q + CNT_ONE;
            end

            case (state_q)
                WAIT_RISE: begin
                    if (rise) begin
                        per_cnt_d = CNT_ONE;
                        hi_cnt_d  = CNT_ONE;
                        state_d   = MEAS_HIGH;
                    end
                end
                MEAS_HIGH: begin
                    per_cnt_d = per_cnt_q + CNT_ONE;
                    if (fall) begin
                        state_d = MEAS_LOW;
                    end else begin
                        hi_cnt_d = hi_cnt_q + CNT_ONE;
                    end
                end
                MEAS_LOW: begin
                    if (rise) begin
                        period_d    = per_cnt_q;
                        high_time_d = hi_cnt_q;
                        duty_d      = (hi_cnt_q > CNT_W'(DUTY_MAX)) ? DUTY_MAX : hi_cnt_q[7:0];
                        valid_d     = 1'b1;
                        per_cnt_d   = CNT_ONE;
                        hi_cnt_d    = CNT_ONE;
                        state_d     = MEAS_HIGH;
                    end else begin
                        per_cnt_d = per_cnt_q + CNT_ONE;
                    end
                end
                default: begin
                    state_d = WAIT_RISE;
                end
            endcase

            if (timeout) begin
                period_d    = CNT_ZERO;
                valid_d     = 1'b1;
                state_d     = WAIT_RISE;
                per_cnt_d   = CNT_ZERO;
                hi_cnt_d    = CNT_ZERO;
                high_time_d = lvl ? CNT_MAX : CNT_ZERO;
                duty_d      = lvl ? DUTY_MAX : 8'h00;
                stuck_hi_d  = lvl;
                stuck_lo_d  = ~lvl;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= WAIT_RISE;
            per_cnt_q   <= CNT_ZERO;
            hi_cnt_q    <= CNT_ZERO;
            to_cnt_q    <= CNT_ZERO;
            period_q    <= CNT_ZERO;
            high_time_q <= CNT_ZERO;
            duty_q      <= 8'h00;
            valid_q     <= 1'b0;
            stuck_hi_q  <= 1'b0;
            stuck_lo_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            per_cnt_q   <= per_cnt_d;
            hi_cnt_q    <= hi_cnt_d;
            to_cnt_q    <= to_cnt_d;
            period_q    <= period_d;
            high_time_q <= high_time_d;
            duty_q      <= duty_d;
            valid_q     <= valid_d;
            stuck_hi_q  <= stuck_hi_d;
            stuck_lo_q  <= stuck_lo_d;
        end
    end

    assign duty_cycle = duty_q;
    assign high_time  = high_time_q;
    assign period     = period_q;
    assign meas_valid = valid_q;
    assign stuck_hi   = stuck_hi_q;
    assign stuck_lo   = stuck_lo_q;

endmodule

// File: tb/tb_pwm_capture.sv
module tb_pwm_capture;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic en  = 1'b1;
    logic pwm16 = 1'b0;
    logic pwm8  = 1'b0;

    logic [7:0]  duty16, duty8;
    logic [15:0] high16, per16;
    logic [7:0]  high8, per8;
    logic        val16, val8, shi16, slo16, shi8, slo8;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    pwm_capture #(.CNT_W(16)) u_dut (
        .clk(clk), .rst(rst), .en(en), .pwm_in(pwm16),
        .duty_cycle(duty16), .high_time(high16), .period(per16),
        .meas_valid(val16), .stuck_hi(shi16), .stuck_lo(slo16)
    );

    pwm_capture #(.CNT_W(8)) u_dut8 (
        .clk(clk), .rst(rst), .en(en), .pwm_in(pwm8),
        .duty_cycle(duty8), .high_time(high8), .period(per8),
        .meas_valid(val8), .stuck_hi(shi8), .stuck_lo(slo8)
    );

    // Cycle counter and meas_valid monitor for the 16-bit instance.
    int cyc = 0;
    int vcnt = 0;
    int wide_cnt = 0;
    int last_cyc = 0;
    int prev_cyc = 0;
    logic prev_v = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (val16) begin
            vcnt     = vcnt + 1;
            prev_cyc = last_cyc;
            last_cyc = cyc;
            if (prev_v) wide_cnt = wide_cnt + 1;
        end
        prev_v = val16;
    end

    task automatic hold16(input logic v, input int n);
        pwm16 = v;
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; en = 1'b1; pwm16 = 1'b0; pwm8 = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst = 1'b1; pwm16 = 1'b1; pwm8 = 1'b1;
        repeat (4) @(negedge clk);
        n_cmp++; if (duty16 !== 8'd0)  begin n_fail++; $display("FAIL reset_duty got=%0d exp=0", duty16); end
        n_cmp++; if (high16 !== 16'd0) begin n_fail++; $display("FAIL reset_high got=%0d exp=0", high16); end
        n_cmp++; if (per16 !== 16'd0)  begin n_fail++; $display("FAIL reset_period got=%0d exp=0", per16); end
        n_cmp++; if ({val16, shi16, slo16} !== 3'b000) begin n_fail++; $display("FAIL reset_flags got=%b exp=000", {val16, shi16, slo16}); end
        n_cmp++; if ({val8, shi8, slo8, duty8} !== 11'd0) begin n_fail++; $display("FAIL reset_dut8 got=%h exp=0", {val8, shi8, slo8, duty8}); end
        pwm16 = 1'b0; pwm8 = 1'b0;
    endtask

    // Duty 64 of a 256-cycle frame, as the PWM generator produces it.
    task automatic test_loopback();
        int v0;
        do_reset();
        v0 = vcnt;
        hold16(1'b0, 10);
        for (int i = 0; i < 4; i++) begin
            hold16(1'b1, 64);
            hold16(1'b0, 192);
        end
        hold16(1'b1, 8);
        n_cmp++; if (vcnt - v0 !== 4) begin n_fail++; $display("FAIL loop_count got=%0d exp=4", vcnt - v0); end
        n_cmp++; if (per16 !== 16'd256) begin n_fail++; $display("FAIL loop_period got=%0d exp=256", per16); end
        n_cmp++; if (high16 !== 16'd64) begin n_fail++; $display("FAIL loop_high got=%0d exp=64", high16); end
        n_cmp++; if (duty16 !== 8'd64)  begin n_fail++; $display("FAIL loop_duty got=%0d exp=64", duty16); end
        n_cmp++; if (last_cyc - prev_cyc !== 256) begin n_fail++; $display("FAIL loop_interval got=%0d exp=256", last_cyc - prev_cyc); end
        n_cmp++; if (wide_cnt !== 0) begin n_fail++; $display("FAIL loop_pulse_width got=%0d exp=0", wide_cnt); end
    endtask

    task automatic test_duty_255();
        int v0;
        do_reset();
        v0 = vcnt;
        hold16(1'b0, 10);
        for (int i = 0; i < 3; i++) begin
            hold16(1'b1, 255);
            hold16(1'b0, 1);
        end
        hold16(1'b1, 8);
        n_cmp++; if (vcnt - v0 !== 3) begin n_fail++; $display("FAIL d255_count got=%0d exp=3", vcnt - v0); end
        n_cmp++; if (per16 !== 16'd256) begin n_fail++; $display("FAIL d255_period got=%0d exp=256", per16); end
        n_cmp++; if (duty16 !== 8'd255) begin n_fail++; $display("FAIL d255_duty got=%0d exp=255", duty16); end
        n_cmp++; if ({shi16, slo16} !== 2'b00) begin n_fail++; $display("FAIL d255_stuck got=%b exp=00", {shi16, slo16}); end
    endtask

    task automatic test_saturate();
        do_reset();
        hold16(1'b0, 10);
        for (int i = 0; i < 2; i++) begin
            hold16(1'b1, 300);
            hold16(1'b0, 100);
        end
        hold16(1'b1, 8);
        n_cmp++; if (high16 !== 16'd300) begin n_fail++; $display("FAIL sat_high got=%0d exp=300", high16); end
        n_cmp++; if (duty16 !== 8'd255)  begin n_fail++; $display("FAIL sat_duty got=%0d exp=255", duty16); end
        n_cmp++; if (per16 !== 16'd400)  begin n_fail++; $display("FAIL sat_period got=%0d exp=400", per16); end
    endtask

    task automatic test_rst_mid();
        int v0;
        do_reset();
        hold16(1'b0, 10);
        for (int i = 0; i < 2; i++) begin
            hold16(1'b1, 100);
            hold16(1'b0, 100);
        end
        hold16(1'b1, 100);
        hold16(1'b0, 50);
        n_cmp++; if (per16 !== 16'd200) begin n_fail++; $display("FAIL rstmid_before got=%0d exp=200", per16); end
        rst = 1'b1;
        repeat (2) @(negedge clk);
        n_cmp++; if ({per16, high16, duty16} !== 40'd0) begin n_fail++; $display("FAIL rstmid_clear got=%h exp=0", {per16, high16, duty16}); end
        rst = 1'b0;
        v0 = vcnt;
        hold16(1'b0, 50);
        hold16(1'b1, 100);
        hold16(1'b0, 100);
        n_cmp++; if (vcnt - v0 !== 0) begin n_fail++; $display("FAIL rstmid_early got=%0d exp=0", vcnt - v0); end
        hold16(1'b1, 8);
        n_cmp++; if (vcnt - v0 !== 1) begin n_fail++; $display("FAIL rstmid_count got=%0d exp=1", vcnt - v0); end
        n_cmp++; if (per16 !== 16'd200) begin n_fail++; $display("FAIL rstmid_period got=%0d exp=200", per16); end
    endtask

    task automatic test_en_drop();
        int v0, v1;
        do_reset();
        v0 = vcnt;
        hold16(1'b0, 10);
        hold16(1'b1, 100);
        hold16(1'b0, 100);
        hold16(1'b1, 30);
        en = 1'b0;
        v1 = vcnt;
        hold16(1'b1, 10);
        n_cmp++; if (vcnt - v1 !== 0) begin n_fail++; $display("FAIL en_valid got=%0d exp=0", vcnt - v1); end
        n_cmp++; if ({per16, high16} !== {16'd200, 16'd100}) begin n_fail++; $display("FAIL en_hold got=%0d/%0d exp=200/100", per16, high16); end
        en = 1'b1;
        hold16(1'b1, 60);
        hold16(1'b0, 100);
        hold16(1'b1, 100);
        hold16(1'b0, 100);
        n_cmp++; if (vcnt - v0 !== 1) begin n_fail++; $display("FAIL en_no_partial got=%0d exp=1", vcnt - v0); end
        hold16(1'b1, 8);
        n_cmp++; if (vcnt - v0 !== 2) begin n_fail++; $display("FAIL en_count got=%0d exp=2", vcnt - v0); end
        n_cmp++; if ({per16, high16} !== {16'd200, 16'd100}) begin n_fail++; $display("FAIL en_meas got=%0d/%0d exp=200/100", per16, high16); end
    endtask

    task automatic test_glitch();
        int v0;
        int exp_cnt, exp_per, exp_hi;
`ifdef PWM_CAPTURE_FILTER_EN
        exp_cnt = 2; exp_per = 200; exp_hi = 100;
`else
        exp_cnt = 3; exp_per = 60;  exp_hi = 2;
`endif
        do_reset();
        v0 = vcnt;
        hold16(1'b0, 10);
        hold16(1'b1, 100);
        hold16(1'b0, 100);
        hold16(1'b1, 100);
        hold16(1'b0, 40);
        hold16(1'b1, 2);
        hold16(1'b0, 58);
        hold16(1'b1, 8);
        n_cmp++; if (vcnt - v0 !== exp_cnt) begin n_fail++; $display("FAIL glitch_count got=%0d exp=%0d", vcnt - v0, exp_cnt); end
        n_cmp++; if (per16 !== 16'(exp_per)) begin n_fail++; $display("FAIL glitch_period got=%0d exp=%0d", per16, exp_per); end
        n_cmp++; if (high16 !== 16'(exp_hi)) begin n_fail++; $display("FAIL glitch_high got=%0d exp=%0d", high16, exp_hi); end
    endtask

    // CNT_W=8 instance: stuck-high timeout, release by a fall, stuck-low.
    task automatic test_stuck();
        int n, extra;
        logic seen;
        do_reset();
        pwm8 = 1'b1;
        n = 0; seen = 1'b0;
        while (!seen && n < 400) begin
            @(negedge clk);
            n++;
            if (val8) seen = 1'b1;
        end
        n_cmp++; if (n !== 259) begin n_fail++; $display("FAIL stuckhi_latency got=%0d exp=259", n); end
        n_cmp++; if ({shi8, slo8} !== 2'b10) begin n_fail++; $display("FAIL stuckhi_flags got=%b exp=10", {shi8, slo8}); end
        n_cmp++; if ({high8, duty8, per8} !== {8'hFF, 8'hFF, 8'h00}) begin n_fail++; $display("FAIL stuckhi_meas got=%h exp=ffff00", {high8, duty8, per8}); end
        extra = 0;
        repeat (30) begin @(negedge clk); if (val8) extra++; end
        n_cmp++; if (extra !== 0) begin n_fail++; $display("FAIL stuckhi_repulse got=%0d exp=0", extra); end
        n_cmp++; if (shi8 !== 1'b1) begin n_fail++; $display("FAIL stuckhi_hold got=%b exp=1", shi8); end
        pwm8 = 1'b0;
        n = 0; seen = 1'b0; extra = 0;
        repeat (6) begin @(negedge clk); n++; if (val8) extra++; end
        n_cmp++; if ({shi8, extra} !== {1'b0, 32'd0}) begin n_fail++; $display("FAIL fall_clear got=%b/%0d exp=0/0", shi8, extra); end
        while (!seen && n < 400) begin
            @(negedge clk);
            n++;
            if (val8) seen = 1'b1;
        end
        n_cmp++; if (n !== 259) begin n_fail++; $display("FAIL stucklo_latency got=%0d exp=259", n); end
        n_cmp++; if ({shi8, slo8} !== 2'b01) begin n_fail++; $display("FAIL stucklo_flags got=%b exp=01", {shi8, slo8}); end
        n_cmp++; if ({high8, duty8, per8} !== 24'd0) begin n_fail++; $display("FAIL stucklo_meas got=%h exp=0", {high8, duty8, per8}); end
        @(negedge clk);
        n_cmp++; if (val8 !== 1'b0) begin n_fail++; $display("FAIL stucklo_pulse got=%b exp=0", val8); end
    endtask

    initial begin
        test_reset();
        test_loopback();
        test_duty_255();
        test_saturate();
        test_rst_mid();
        test_en_drop();
        test_glitch();
        test_stuck();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
